// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder:
// FSM state encodings and the default operand width.
package serial_adder_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit full adder built from plain gates;
// the serial adder reuses it once per cycle.
module full_adder_cell (
  output logic cout,
  output logic s,
  input  logic a,
  input  logic b,
  input  logic cin
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, carry kept
// in a flop, result assembled LSB-first over WIDTH cycles.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rs;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic             s;
  logic             c;
  logic [WIDTH-1:0] rs_next;

  full_adder_cell u_fa (
    .cout (c),
    .s    (s),
    .a    (ra[0]),
    .b    (rb[0]),
    .cin  (cy)
  );

  // Next partial result: new sum bit enters at the MSB
  assign rs_next = {s, rs[WIDTH-1:1]};

  // Status flags decode straight from the state register
  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  // FSM, operand shifters, carry, counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      rs    <= '0;
      cy    <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ra    <= a;
            rb    <= b;
            cy    <= cin;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          ra  <= {1'b0, ra[WIDTH-1:1]};
          rb  <= {1'b0, rb[WIDTH-1:1]};
          rs  <= rs_next;
          cy  <= c;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum   <= rs_next;
            cout  <= c;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
